// File: rtl/nim_pkg.sv
// Nim board shared types, sizes and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a; buttons are one-cycle pulses and are never stalled.
package nim_pkg;

    typedef enum logic [1:0] {SELECT, TAKING, CHECK, OVER} state_t;

    localparam int NUM_PILES  = 4;
    localparam int PILE_W     = 4;
    localparam int MAX_STONES = 8;

    typedef enum logic [1:0] {PLANE_RED, PLANE_GREEN, PLANE_BLUE} plane_t;

    // Player register value 0 is shown as "1" and drawn red, 1 as "2" drawn blue.
    localparam plane_t PLAYER1 = PLANE_RED;
    localparam plane_t PLAYER2 = PLANE_BLUE;

    typedef logic [0:7][7:0] image_t;
    typedef logic [NUM_PILES-1:0][PILE_W-1:0] piles_t;

    function automatic plane_t player_plane(input logic player);
        return player ? PLAYER2 : PLAYER1;
    endfunction

    // n stones light the n lowest (bottom) rows of a column.
    function automatic logic [7:0] stone_mask(input logic [PILE_W-1:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return (n > PILE_W'(MAX_STONES)) ? 8'hFF : m[7:0];
    endfunction

    function automatic logic [PILE_W-1:0] clamp_init(input int v);
        if (v > MAX_STONES) return PILE_W'(MAX_STONES);
        if (v < 0)          return '0;
        return PILE_W'(v);
    endfunction

endpackage

// File: rtl/nim_image_render.sv
// Renders piles/selection/player or the blinking winner screen into LED planes and hex digits.
// Latency: 1 cycle, every output is registered from the current game state.
// Backpressure: none; downstream drivers sample the registers continuously.
// Ports: clk/reset; i_piles, i_sel, i_player, i_taken, i_state, i_phase in;
//        image_red/green/blue, in0..in3, game_over out.
module nim_image_render
    import nim_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  piles_t      i_piles,
    input  logic [1:0]  i_sel,
    input  logic        i_player,
    input  logic [3:0]  i_taken,
    input  state_t      i_state,
    input  logic        i_phase,
    output image_t      image_red,
    output image_t      image_green,
    output image_t      image_blue,
    output logic [3:0]  in0,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3,
    output logic        game_over
);

    image_t     w_red, w_green, w_blue;
    logic [3:0] w_in0, w_in1, w_in2, w_in3;
    logic       w_over;

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        w_in0   = '0;
        w_in1   = '0;
        w_in2   = '0;
        w_in3   = {3'b000, i_player} + 4'd1;
        w_over  = 1'b0;
        if (i_state == OVER) begin
            // Winner is the player who made the last take; it is never toggled after that.
            w_over = 1'b1;
            if (i_phase) begin
                if (player_plane(i_player) == PLANE_RED) w_red  = '1;
                else                                      w_blue = '1;
            end
        end else begin
            for (int k = 0; k < NUM_PILES; k++) begin
                if (2'(k) == i_sel) begin
                    if (player_plane(i_player) == PLANE_RED) begin
                        w_red[2*k]   = stone_mask(i_piles[k]);
                        w_red[2*k+1] = stone_mask(i_piles[k]);
                    end else begin
                        w_blue[2*k]   = stone_mask(i_piles[k]);
                        w_blue[2*k+1] = stone_mask(i_piles[k]);
                    end
                end else begin
                    w_green[2*k]   = stone_mask(i_piles[k]);
                    w_green[2*k+1] = stone_mask(i_piles[k]);
                end
            end
            w_in0 = i_piles[i_sel];
            w_in1 = {2'b00, i_sel};
            w_in2 = i_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            image_red   <= '0;
            image_green <= '0;
            image_blue  <= '0;
            in0         <= '0;
            in1         <= '0;
            in2         <= '0;
            in3         <= '0;
            game_over   <= 1'b0;
        end else begin
            image_red   <= w_red;
            image_green <= w_green;
            image_blue  <= w_blue;
            in0         <= w_in0;
            in1         <= w_in1;
            in2         <= w_in2;
            in3         <= w_in3;
            game_over   <= w_over;
        end
    end

endmodule

// File: rtl/nim_board_ctrl.sv
// Nim game logic: four piles, turn FSM and winner blink timer, driving LED/7-seg images.
// Latency: pulse updates state at the sampling edge, outputs follow one edge later (2 cycles).
// Backpressure: none; pulses that are not legal in the current state are dropped.
// Ports: clk, reset, btn_sel/take/end/new pulses in; image_red/green/blue, in0..in3, game_over out.
module nim_board_ctrl
    import nim_pkg::*;
#(
    parameter int INIT_P0   = 1,
    parameter int INIT_P1   = 3,
    parameter int INIT_P2   = 5,
    parameter int INIT_P3   = 7,
    parameter int BLINK_DIV = 25_000_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_sel,
    input  logic        btn_take,
    input  logic        btn_end,
    input  logic        btn_new,
    output image_t      image_red,
    output image_t      image_green,
    output image_t      image_blue,
    output logic [3:0]  in0,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3,
    output logic        game_over
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam piles_t INIT_PILES = {clamp_init(INIT_P3), clamp_init(INIT_P2),
                                     clamp_init(INIT_P1), clamp_init(INIT_P0)};

    state_t             r_state, w_state_nxt;
    piles_t             r_piles, w_piles_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic               r_player, w_player_nxt;
    logic [3:0]         r_taken, w_taken_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_phase, w_phase_nxt;
    logic [PILE_W-1:0]  w_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SELECT;
            r_piles  <= INIT_PILES;
            r_sel    <= '0;
            r_player <= 1'b0;
            r_taken  <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_piles  <= w_piles_nxt;
            r_sel    <= w_sel_nxt;
            r_player <= w_player_nxt;
            r_taken  <= w_taken_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
        end
    end

    // Only the highest-priority pulse is considered; if that one is not legal
    // in the current state, the cycle does nothing.
    always_comb begin
        w_state_nxt  = r_state;
        w_piles_nxt  = r_piles;
        w_sel_nxt    = r_sel;
        w_player_nxt = r_player;
        w_taken_nxt  = r_taken;
        w_cnt_nxt    = r_cnt;
        w_phase_nxt  = r_phase;
        w_cur        = r_piles[r_sel];
        if (btn_new) begin
            w_state_nxt  = SELECT;
            w_piles_nxt  = INIT_PILES;
            w_sel_nxt    = '0;
            w_player_nxt = 1'b0;
            w_taken_nxt  = '0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                SELECT: begin
                    if (!btn_end) begin
                        if (btn_take) begin
                            if (w_cur != '0) begin
                                w_piles_nxt[r_sel] = w_cur - 1'b1;
                                w_taken_nxt        = 4'd1;
                                w_state_nxt        = TAKING;
                            end
                        end else if (btn_sel) begin
                            w_sel_nxt = r_sel + 2'd1;
                        end
                    end
                end
                TAKING: begin
                    if (btn_end) begin
                        w_state_nxt = CHECK;
                    end else if (btn_take && (w_cur != '0) && (r_taken < 4'(MAX_STONES))) begin
                        w_piles_nxt[r_sel] = w_cur - 1'b1;
                        w_taken_nxt        = r_taken + 4'd1;
                    end
                end
                CHECK: begin
                    if (r_piles == '0) begin
                        w_state_nxt = OVER;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = SELECT;
                        w_player_nxt = ~r_player;
                        w_taken_nxt  = '0;
                    end
                end
                OVER: begin
                    if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
                        w_cnt_nxt   = '0;
                        w_phase_nxt = ~r_phase;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = SELECT;
            endcase
        end
    end

    nim_image_render u_render (
        .clk         (clk),
        .reset       (reset),
        .i_piles     (r_piles),
        .i_sel       (r_sel),
        .i_player    (r_player),
        .i_taken     (r_taken),
        .i_state     (r_state),
        .i_phase     (r_phase),
        .image_red   (image_red),
        .image_green (image_green),
        .image_blue  (image_blue),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .game_over   (game_over)
    );

endmodule

// File: tb/tb_nim_board_ctrl.sv
// Directed bench for nim_board_ctrl with a short blink period.
// Latency: checks sample on the falling edge after outputs settle.
// Backpressure: n/a.
module tb_nim_board_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_sel, btn_take, btn_end, btn_new;
    logic [0:7][7:0]   image_red, image_green, image_blue;
    logic [3:0]        in0, in1, in2, in3;
    logic              game_over;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [63:0] INIT_RED   = 64'h0101_0000_0000_0000;
    localparam logic [63:0] INIT_GREEN = 64'h0000_0707_1F1F_7F7F;

    always #5 clk = ~clk;

    nim_board_ctrl #(.BLINK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_sel     (btn_sel),
        .btn_take    (btn_take),
        .btn_end     (btn_end),
        .btn_new     (btn_new),
        .image_red   (image_red),
        .image_green (image_green),
        .image_blue  (image_blue),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .game_over   (game_over)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse on any combination of buttons: {new,end,take,sel}.
    task automatic pulse(input logic [3:0] b);
        @(negedge clk);
        {btn_new, btn_end, btn_take, btn_sel} = b;
        @(negedge clk);
        {btn_new, btn_end, btn_take, btn_sel} = 4'b0000;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    localparam logic [3:0] SEL = 4'b0001, TAKE = 4'b0010, ENDT = 4'b0100, NEWG = 4'b1000;

    initial begin
        reset = 1'b1;
        {btn_new, btn_end, btn_take, btn_sel} = 4'b0000;
        wait_neg(3);
        chk("rst_red", image_red, 64'h0);
        chk("rst_green", image_green, 64'h0);
        chk("rst_in3", {60'h0, in3}, 64'h0);
        chk("rst_over", {63'h0, game_over}, 64'h0);

        reset = 1'b0;
        wait_neg(2);
        chk("init_red", image_red, INIT_RED);
        chk("init_green", image_green, INIT_GREEN);
        chk("init_blue", image_blue, 64'h0);
        chk("init_digits", {48'h0, in3, in2, in1, in0}, 64'h1001);

        // Player 1 takes two from pile 3.
        pulse(SEL); pulse(SEL); pulse(SEL);
        pulse(TAKE); pulse(TAKE);
        wait_neg(1);
        chk("take2_digits", {48'h0, in3, in2, in1, in0}, 64'h1235);
        chk("take2_red", image_red, 64'h0000_0000_0000_1F1F);
        chk("take2_green", image_green, 64'h0101_0707_1F1F_0000);
        pulse(SEL);
        wait_neg(1);
        chk("sel_locked", {60'h0, in1}, 64'h3);
        pulse(ENDT);
        wait_neg(2);
        chk("turn2_digits", {48'h0, in3, in2, in1, in0}, 64'h2035);
        chk("turn2_blue", image_blue, 64'h0000_0000_0000_1F1F);
        chk("turn2_red", image_red, 64'h0);

        // End with nothing taken is ignored.
        pulse(ENDT);
        wait_neg(2);
        chk("end_ignored", {48'h0, in3, in2, in1, in0}, 64'h2035);

        // Player 2 empties pile 0; an extra take on the empty pile does nothing.
        pulse(SEL); pulse(TAKE); pulse(TAKE);
        wait_neg(1);
        chk("empty_take_digits", {48'h0, in3, in2, in1, in0}, 64'h2100);
        chk("empty_take_green", image_green, 64'h0000_0707_1F1F_1F1F);
        pulse(ENDT);
        pulse(TAKE);
        wait_neg(1);
        chk("select_empty_take", {48'h0, in3, in2, in1, in0}, 64'h1000);
        chk("select_empty_red", image_red, 64'h0);

        // New game beats a simultaneous take while TAKING.
        pulse(SEL); pulse(TAKE);
        wait_neg(1);
        chk("pre_new_digits", {48'h0, in3, in2, in1, in0}, 64'h1112);
        pulse(NEWG | TAKE);
        wait_neg(1);
        chk("new_red", image_red, INIT_RED);
        chk("new_green", image_green, INIT_GREEN);
        chk("new_digits", {48'h0, in3, in2, in1, in0}, 64'h1001);

        // Play to the end with player 1 taking the last stone.
        pulse(TAKE); pulse(ENDT);
        pulse(SEL); pulse(TAKE); pulse(TAKE); pulse(ENDT);
        pulse(TAKE); pulse(ENDT);
        pulse(SEL); for (int i = 0; i < 5; i++) pulse(TAKE); pulse(ENDT);
        pulse(SEL); for (int i = 0; i < 7; i++) pulse(TAKE);
        wait_neg(1);
        chk("last_turn_digits", {48'h0, in3, in2, in1, in0}, 64'h1730);
        pulse(ENDT);
        wait_neg(2);
        chk("over_flag", {63'h0, game_over}, 64'h1);
        chk("over_digits", {48'h0, in3, in2, in1, in0}, 64'h1000);
        chk("over_on_red", image_red, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("over_on_blue", image_blue, 64'h0);
        chk("over_on_green", image_green, 64'h0);
        wait_neg(4);
        chk("over_off_red", image_red, 64'h0);
        chk("over_off_blue", image_blue, 64'h0);
        chk("over_off_flag", {63'h0, game_over}, 64'h1);
        wait_neg(4);
        chk("over_on2_red", image_red, 64'hFFFF_FFFF_FFFF_FFFF);
        pulse(TAKE); pulse(SEL); pulse(ENDT);
        wait_neg(1);
        chk("over_ignore", {59'h0, game_over, in3}, 64'h11);

        pulse(NEWG);
        wait_neg(1);
        chk("restart_flag", {63'h0, game_over}, 64'h0);
        chk("restart_red", image_red, INIT_RED);

        // Reset in the middle of a turn.
        pulse(TAKE);
        wait_neg(1);
        chk("pre_rst_in2", {60'h0, in2}, 64'h1);
        reset = 1'b1;
        wait_neg(1);
        chk("midrst_red", image_red, 64'h0);
        chk("midrst_digits", {48'h0, in3, in2, in1, in0}, 64'h0);
        reset = 1'b0;
        wait_neg(2);
        chk("postrst_red", image_red, INIT_RED);
        chk("postrst_green", image_green, INIT_GREEN);
        chk("postrst_digits", {48'h0, in3, in2, in1, in0}, 64'h1001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
